ltl_report_collector: RTL

// - Downstream consumer of an Automata_ltl* cluster: samples its report outputs (active_state of report STEs) each symbol.
// - Tags every non-empty report vector with the index of the symbol that produced it and queues it in a FIFO.
// - Exposes the FIFO to the monitor readout logic over valid/ready, with sticky per-report flags and a saturating drop counter.

---
 rtl/ltl_monitor_pkg.sv | 18 +
 rtl/ltl_report_fifo.sv | 60 ++++++
 rtl/ltl_report_collector.sv | 112 +++++++++++
 3 files changed

// File: rtl/ltl_monitor_pkg.sv
// Shared types and helpers for the LTL automata report monitor.
// Holds the default report-entry layout and the FIFO pointer-width function.
package ltl_monitor_pkg;

  localparam int LTL_NUM_REPORTS = 4;
  localparam int LTL_IDX_W       = 32;

  typedef struct packed {
    logic [LTL_IDX_W-1:0]       idx;
    logic [LTL_NUM_REPORTS-1:0] rpt;
  } ltl_report_entry_t;

  // Pointer width for a power-of-two FIFO depth (never narrower than one bit).
  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous first-in first-out queue of report entries.
// Head is read straight from storage flops; a push into a full queue succeeds only alongside a pop.
module ltl_report_fifo
  import ltl_monitor_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = ltl_report_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PW = fifo_ptr_w(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ltl_report_collector.sv
// Samples automata report outputs one cycle after each consumed symbol, tags them with
// the symbol index and queues them for readout, tracking sticky flags and dropped entries.
module ltl_report_collector
  import ltl_monitor_pkg::*;
#(
  parameter int NUM_REPORTS = 4,
  parameter int IDX_W       = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int EDGE_MODE   = 1,
  parameter int DROP_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] reports,
  input  logic [NUM_REPORTS-1:0] report_mask,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic [NUM_REPORTS-1:0] out_reports,
  output logic [NUM_REPORTS-1:0] sticky,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  typedef struct packed {
    logic [IDX_W-1:0]       idx;
    logic [NUM_REPORTS-1:0] rpt;
  } entry_t;

  logic                   run_q;
  logic [IDX_W-1:0]       sym_idx;
  logic [IDX_W-1:0]       tag_idx;
  logic [NUM_REPORTS-1:0] prev;
  logic [NUM_REPORTS-1:0] cur;
  logic [NUM_REPORTS-1:0] cand;
  logic                   push_req;
  logic                   pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  entry_t                 push_data;
  entry_t                 head;
  logic [NUM_REPORTS-1:0] sticky_base;
  logic                   overflow_base;
  logic [DROP_W-1:0]      drop_base;

  // The automata register on the run cycle, so their reports are valid while run_q is high.
  assign cur      = reports & report_mask;
  assign cand     = (EDGE_MODE != 0) ? (cur & ~prev) : cur;
  assign push_req = run_q & (|cand);
  assign push_data = {tag_idx, cand};

  // Readout handshake: the head entry transfers on any cycle with out_valid & out_ready;
  // out_valid never depends on out_ready and the head holds steady until it transfers.
  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;
  assign out_idx     = out_valid ? head.idx : '0;
  assign out_reports = out_valid ? head.rpt : '0;

  // A full queue still accepts a push when the head leaves on the same cycle.
  assign drop = push_req & fifo_full & ~pop;

  // Clear wipes history first; a same-cycle push request is then applied on top.
  assign sticky_base   = clear ? '0 : sticky;
  assign overflow_base = clear ? 1'b0 : overflow;
  assign drop_base     = clear ? '0 : drop_count;

  ltl_report_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 1'b0;
      sym_idx    <= '0;
      tag_idx    <= '0;
      prev       <= '0;
      sticky     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      run_q <= run;
      if (run) begin
        tag_idx <= sym_idx;
        sym_idx <= sym_idx + 1'b1;
      end
      if (run_q) begin
        prev <= cur;
      end
      sticky   <= sticky_base | (push_req ? cand : '0);
      overflow <= overflow_base | drop;
      if (drop && (~&drop_base)) begin
        drop_count <= drop_base + 1'b1;
      end else begin
        drop_count <= drop_base;
      end
    end
  end

endmodule
